seq_divider: RTL and testbench



---
 rtl/seq_divider.sv | 216 +++++++++++++++++++++
 tb/tb_seq_divider.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_divider.sv
// -----------------------------------------------------------------------------
// seq_divider
// Multi-cycle restoring divider. Each operation is accepted through a
// valid/ready handshake. The divider then produces one quotient bit per clock,
// MSB first. The result is returned through a second valid/ready handshake.
// With SIGNED=1 the operands are two's complement and the results truncate
// toward zero, so the remainder takes the sign of the dividend.
//
// Parameters
//   WIDTH   operand/result width in bits (4..32)
//   SIGNED  0 = unsigned operands, 1 = two's-complement operands
//
// Ports
//   CLK          system clock; all state updates on the rising edge
//   RESET        asynchronous active-low reset
//   in_valid     numer/denom valid
//   in_ready     divider can accept an operation (registered, high only in IDLE)
//   numer        dividend
//   denom        divisor
//   out_valid    quotient/remain/div_by_zero valid
//   out_ready    consumer accepts the result
//   quotient     quotient
//   remain       remainder
//   div_by_zero  denom was zero for this result
// -----------------------------------------------------------------------------
module seq_divider #(
    parameter int WIDTH  = 16,
    parameter bit SIGNED = 1'b0
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] numer,
    input  logic [WIDTH-1:0] denom,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remain,
    output logic             div_by_zero
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t           state_reg, state_next;
    logic [CW-1:0]    cnt_reg, cnt_next;
    logic [WIDTH-1:0] prem_reg, prem_next;     // partial remainder
    logic [WIDTH-1:0] quo_reg, quo_next;       // dividend bits shift out, quotient bits shift in
    logic [WIDTH-1:0] dvs_reg, dvs_next;       // divisor magnitude
    logic [WIDTH-1:0] numer_reg, numer_next;   // original dividend bits (needed for the zero-divisor remainder)
    logic             qneg_reg, qneg_next;
    logic             rneg_reg, rneg_next;
    logic             dbz_reg, dbz_next;
    logic             in_ready_reg, in_ready_next;
    logic             out_valid_reg, out_valid_next;
    logic [WIDTH-1:0] quotient_reg, quotient_next;
    logic [WIDTH-1:0] remain_reg, remain_next;
    logic             div_by_zero_reg, div_by_zero_next;

    // Operand magnitudes and signs. The magnitudes are WIDTH-bit unsigned
    // values, so |-2^(WIDTH-1)| = 2^(WIDTH-1) is still represented exactly.
    logic             numer_neg, denom_neg;
    logic [WIDTH-1:0] numer_mag, denom_mag;

    generate
        if (SIGNED) begin : g_signed
            assign numer_neg = numer[WIDTH-1];
            assign denom_neg = denom[WIDTH-1];
            assign numer_mag = numer_neg ? -numer : numer;
            assign denom_mag = denom_neg ? -denom : denom;
        end else begin : g_unsigned
            assign numer_neg = 1'b0;
            assign denom_neg = 1'b0;
            assign numer_mag = numer;
            assign denom_mag = denom;
        end
    endgenerate

    // One restoring step. The previous partial remainder is always below the
    // divisor, so after shifting in one dividend bit it fits in WIDTH+1 bits.
    // The top bit of the difference therefore acts as the borrow.
    logic [WIDTH:0] shifted;
    logic [WIDTH:0] diff;

    assign shifted = {prem_reg, quo_reg[WIDTH-1]};
    assign diff    = shifted - {1'b0, dvs_reg};

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_reg       <= IDLE;
            cnt_reg         <= '0;
            prem_reg        <= '0;
            quo_reg         <= '0;
            dvs_reg         <= '0;
            numer_reg       <= '0;
            qneg_reg        <= 1'b0;
            rneg_reg        <= 1'b0;
            dbz_reg         <= 1'b0;
            in_ready_reg    <= 1'b0;
            out_valid_reg   <= 1'b0;
            quotient_reg    <= '0;
            remain_reg      <= '0;
            div_by_zero_reg <= 1'b0;
        end else begin
            state_reg       <= state_next;
            cnt_reg         <= cnt_next;
            prem_reg        <= prem_next;
            quo_reg         <= quo_next;
            dvs_reg         <= dvs_next;
            numer_reg       <= numer_next;
            qneg_reg        <= qneg_next;
            rneg_reg        <= rneg_next;
            dbz_reg         <= dbz_next;
            in_ready_reg    <= in_ready_next;
            out_valid_reg   <= out_valid_next;
            quotient_reg    <= quotient_next;
            remain_reg      <= remain_next;
            div_by_zero_reg <= div_by_zero_next;
        end
    end

    always_comb begin
        state_next       = state_reg;
        cnt_next         = cnt_reg;
        prem_next        = prem_reg;
        quo_next         = quo_reg;
        dvs_next         = dvs_reg;
        numer_next       = numer_reg;
        qneg_next        = qneg_reg;
        rneg_next        = rneg_reg;
        dbz_next         = dbz_reg;
        in_ready_next    = in_ready_reg;
        out_valid_next   = out_valid_reg;
        quotient_next    = quotient_reg;
        remain_next      = remain_reg;
        div_by_zero_next = div_by_zero_reg;

        case (state_reg)
            IDLE: begin
                // in_ready comes up one edge after reset release, or after a
                // result has been consumed.
                in_ready_next = 1'b1;
                if (in_valid && in_ready_reg) begin
                    in_ready_next = 1'b0;
                    prem_next     = '0;
                    quo_next      = numer_mag;
                    dvs_next      = denom_mag;
                    numer_next    = numer;
                    qneg_next     = numer_neg ^ denom_neg;
                    rneg_next     = numer_neg;
                    dbz_next      = (denom == '0);
                    cnt_next      = '0;
                    state_next    = (denom == '0) ? FIX : CALC;
                end
            end

            CALC: begin
                if (diff[WIDTH]) begin
                    prem_next = shifted[WIDTH-1:0];   // restore
                end else begin
                    prem_next = diff[WIDTH-1:0];
                end
                quo_next = {quo_reg[WIDTH-2:0], ~diff[WIDTH]};
                if (cnt_reg == CW'(WIDTH - 1)) begin
                    cnt_next   = '0;
                    state_next = FIX;
                end else begin
                    cnt_next = cnt_reg + CW'(1);
                end
            end

            FIX: begin
                if (dbz_reg) begin
                    quotient_next = '1;
                    remain_next   = numer_reg;
                end else begin
                    // The signed overflow case (-2^(WIDTH-1) / -1) needs no
                    // special handling here. Its magnitude quotient 2^(WIDTH-1)
                    // is positive, and that value reads back as -2^(WIDTH-1).
                    quotient_next = qneg_reg ? -quo_reg : quo_reg;
                    remain_next   = rneg_reg ? -prem_reg : prem_reg;
                end
                div_by_zero_next = dbz_reg;
                out_valid_next   = 1'b1;
                state_next       = DONE;
            end

            DONE: begin
                // Result registers keep their values after the handshake.
                if (out_valid_reg && out_ready) begin
                    out_valid_next = 1'b0;
                    in_ready_next  = 1'b1;
                    state_next     = IDLE;
                end
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign in_ready    = in_ready_reg;
    assign out_valid   = out_valid_reg;
    assign quotient    = quotient_reg;
    assign remain      = remain_reg;
    assign div_by_zero = div_by_zero_reg;

endmodule

// File: tb/tb_seq_divider.sv
// -----------------------------------------------------------------------------
// tb_seq_divider
// Scoreboard bench for seq_divider. It uses two instances with WIDTH=16:
// index 0 is unsigned and index 1 is signed. The stimulus pushes the expected
// result when an operation is accepted. A monitor pops that entry when out_valid
// rises, then checks the data and the latency. The monitor also checks that the
// outputs stay stable while the result is held.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_seq_divider;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid    [2];
    logic        in_ready    [2];
    logic [15:0] numer       [2];
    logic [15:0] denom       [2];
    logic        out_valid   [2];
    logic        out_ready   [2];
    logic [15:0] quotient    [2];
    logic [15:0] remain      [2];
    logic        div_by_zero [2];

    always #5 clk = ~clk;

    seq_divider #(.WIDTH(16), .SIGNED(1'b0)) u_dut_u (
        .CLK(clk), .RESET(rst_n),
        .in_valid(in_valid[0]), .in_ready(in_ready[0]),
        .numer(numer[0]), .denom(denom[0]),
        .out_valid(out_valid[0]), .out_ready(out_ready[0]),
        .quotient(quotient[0]), .remain(remain[0]), .div_by_zero(div_by_zero[0])
    );

    seq_divider #(.WIDTH(16), .SIGNED(1'b1)) u_dut_s (
        .CLK(clk), .RESET(rst_n),
        .in_valid(in_valid[1]), .in_ready(in_ready[1]),
        .numer(numer[1]), .denom(denom[1]),
        .out_valid(out_valid[1]), .out_ready(out_ready[1]),
        .quotient(quotient[1]), .remain(remain[1]), .div_by_zero(div_by_zero[1])
    );

    typedef struct {
        logic [15:0] q;
        logic [15:0] r;
        logic        dbz;
        int          acc;   // cycle stamp of the accept edge
        int          lat;   // expected edges from accept to out_valid
    } exp_t;

    exp_t sb0[$];
    exp_t sb1[$];

    int n_pass  = 0;
    int n_total = 0;
    int cyc     = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_total++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %h, expected %h", nm, act, req);
    endtask

    // ---------------- monitor ----------------
    logic        prev_ov [2] = '{1'b0, 1'b0};
    logic [15:0] held_q  [2];
    logic [15:0] held_r  [2];
    exp_t        mon_e;

    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (out_valid[d] === 1'b1 && prev_ov[d] !== 1'b1) begin
                if ((d == 0 && sb0.size() == 0) || (d == 1 && sb1.size() == 0)) begin
                    n_total++;
                    $display("FAIL dut%0d_unexpected_result: got q=%h r=%h, expected no result",
                             d, quotient[d], remain[d]);
                end else begin
                    if (d == 0) mon_e = sb0.pop_front();
                    else        mon_e = sb1.pop_front();
                    $display("dut%0d result q=%h r=%h dbz=%0d lat=%0d (expected q=%h r=%h dbz=%0d lat=%0d)",
                             d, quotient[d], remain[d], div_by_zero[d], cyc - mon_e.acc,
                             mon_e.q, mon_e.r, mon_e.dbz, mon_e.lat);
                    chk($sformatf("dut%0d_quotient", d), 32'(quotient[d]), 32'(mon_e.q));
                    chk($sformatf("dut%0d_remain", d), 32'(remain[d]), 32'(mon_e.r));
                    chk($sformatf("dut%0d_div_by_zero", d), 32'(div_by_zero[d]), 32'(mon_e.dbz));
                    chk($sformatf("dut%0d_latency", d), 32'(cyc - mon_e.acc), 32'(mon_e.lat));
                end
                held_q[d] <= quotient[d];
                held_r[d] <= remain[d];
            end else if (out_valid[d] === 1'b1) begin
                chk($sformatf("dut%0d_hold_quotient", d), 32'(quotient[d]), 32'(held_q[d]));
                chk($sformatf("dut%0d_hold_remain", d), 32'(remain[d]), 32'(held_r[d]));
            end
            prev_ov[d] <= out_valid[d];
        end
    end

    // ---------------- stimulus ----------------
    task automatic push_exp(input int d, input logic [15:0] q, input logic [15:0] r,
                            input logic dbz, input int lat);
        exp_t e;
        e.q = q; e.r = r; e.dbz = dbz; e.acc = cyc; e.lat = lat;
        if (d == 0) sb0.push_back(e);
        else        sb1.push_back(e);
    endtask

    // Present an operation and hold it until it is accepted. The task returns
    // #1 after the accept edge.
    task automatic issue(input int d, input logic [15:0] n, input logic [15:0] dn,
                         input logic [15:0] q, input logic [15:0] r, input logic dbz,
                         input int lat, input bit push);
        bit ok = 1'b0;
        @(posedge clk); #1;
        in_valid[d] = 1'b1;
        numer[d]    = n;
        denom[d]    = dn;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (in_ready[d] === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            n_total++;
            $display("FAIL dut%0d_accept_timeout: got in_ready=%b, expected 1", d, in_ready[d]);
        end
        @(posedge clk); #1;
        in_valid[d] = 1'b0;
        if (push) push_exp(d, q, r, dbz, lat);
    endtask

    task automatic wait_result(input int d);
        bit ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (out_valid[d] === 1'b1 && out_ready[d] === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            n_total++;
            $display("FAIL dut%0d_result_timeout: got out_valid=%b, expected 1", d, out_valid[d]);
        end
        @(posedge clk); #1;
    endtask

    task automatic run(input int d, input logic [15:0] n, input logic [15:0] dn,
                       input logic [15:0] q, input logic [15:0] r, input logic dbz, input int lat);
        issue(d, n, dn, q, r, dbz, lat, 1'b1);
        wait_result(d);
    endtask

    initial begin
        bit seen;
        rst_n = 1'b0;
        for (int d = 0; d < 2; d++) begin
            in_valid[d]  = 1'b0;
            numer[d]     = '0;
            denom[d]     = '0;
            out_ready[d] = 1'b1;
        end

        // Check the reset state, then the first in_ready edge after release.
        repeat (2) @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("dut%0d_rst_out_valid", d), 32'(out_valid[d]), 32'd0);
            chk($sformatf("dut%0d_rst_in_ready", d), 32'(in_ready[d]), 32'd0);
            chk($sformatf("dut%0d_rst_quotient", d), 32'(quotient[d]), 32'd0);
            chk($sformatf("dut%0d_rst_remain", d), 32'(remain[d]), 32'd0);
            chk($sformatf("dut%0d_rst_dbz", d), 32'(div_by_zero[d]), 32'd0);
        end
        rst_n = 1'b1;
        @(negedge clk);
        chk("dut0_in_ready_after_release", 32'(in_ready[0]), 32'd1);
        chk("dut1_in_ready_after_release", 32'(in_ready[1]), 32'd1);

        // Unsigned directed vectors.
        run(0, 16'd1000, 16'd7,    16'd142,  16'd6,    1'b0, 17);
        run(0, 16'h04D2, 16'h0000, 16'hFFFF, 16'h04D2, 1'b1, 1);
        run(0, 16'hFFFF, 16'h0001, 16'hFFFF, 16'h0000, 1'b0, 17);
        run(0, 16'hFFFF, 16'hFFFF, 16'h0001, 16'h0000, 1'b0, 17);
        run(0, 16'd5,    16'd9,    16'd0,    16'd5,    1'b0, 17);

        // Signed directed vectors.
        run(1, 16'hFFF9, 16'h0002, 16'hFFFD, 16'hFFFF, 1'b0, 17);
        run(1, 16'h0007, 16'hFFFE, 16'hFFFD, 16'h0001, 1'b0, 17);
        run(1, 16'h8000, 16'hFFFF, 16'h8000, 16'h0000, 1'b0, 17);
        run(1, 16'hFFF9, 16'h0000, 16'hFFFF, 16'hFFF9, 1'b1, 1);
        run(1, 16'hFF9C, 16'hFFF7, 16'd11,   16'hFFFF, 1'b0, 17);
        run(1, 16'h8000, 16'h0002, 16'hC000, 16'h0000, 1'b0, 17);

        // Backpressure: hold the 100/9 result while a new operation waits.
        out_ready[0] = 1'b0;
        issue(0, 16'd100, 16'd9, 16'd11, 16'd1, 1'b0, 17, 1'b1);
        seen = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (out_valid[0] === 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
        chk("dut0_bp_out_valid_seen", 32'(seen), 32'd1);
        numer[0]    = 16'd50;
        denom[0]    = 16'd7;
        in_valid[0] = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("dut0_bp_in_ready", 32'(in_ready[0]), 32'd0);
            chk("dut0_bp_out_valid", 32'(out_valid[0]), 32'd1);
        end
        @(posedge clk); #1;
        out_ready[0] = 1'b1;
        @(negedge clk);
        chk("dut0_bp_in_ready_pre_handshake", 32'(in_ready[0]), 32'd0);
        @(negedge clk);
        chk("dut0_bp_out_valid_cleared", 32'(out_valid[0]), 32'd0);
        chk("dut0_bp_in_ready_raised", 32'(in_ready[0]), 32'd1);
        chk("dut0_bp_quotient_kept", 32'(quotient[0]), 32'd11);
        chk("dut0_bp_remain_kept", 32'(remain[0]), 32'd1);
        // in_valid has been high the whole time, so this edge accepts 50/7.
        @(posedge clk); #1;
        in_valid[0] = 1'b0;
        push_exp(0, 16'd7, 16'd1, 1'b0, 17);
        @(negedge clk);
        chk("dut0_bp_accepted", 32'(in_ready[0]), 32'd0);
        wait_result(0);

        // Reset in the middle of CALC, after the 8th iteration of 1000/7.
        issue(0, 16'd1000, 16'd7, 16'd0, 16'd0, 1'b0, 0, 1'b0);
        repeat (8) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("dut0_midrst_out_valid", 32'(out_valid[0]), 32'd0);
        chk("dut0_midrst_in_ready", 32'(in_ready[0]), 32'd0);
        chk("dut0_midrst_quotient", 32'(quotient[0]), 32'd0);
        chk("dut0_midrst_remain", 32'(remain[0]), 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("dut0_release_in_ready_low", 32'(in_ready[0]), 32'd0);
        @(negedge clk);
        chk("dut0_release_in_ready_high", 32'(in_ready[0]), 32'd1);
        // Let enough cycles pass that an abandoned result would have shown up.
        repeat (25) @(negedge clk);
        run(0, 16'd100, 16'd9, 16'd11, 16'd1, 1'b0, 17);

        repeat (5) @(negedge clk);
        chk("dut0_scoreboard_empty", 32'(sb0.size()), 32'd0);
        chk("dut1_scoreboard_empty", 32'(sb1.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
